// File: rtl/vector_store_sequencer.sv
// rtl/vector_store_sequencer.sv - vector store engine: one masked lane per cycle into byte-wide memory
// Captures a full vector, then walks lanes base..base+LANES-1 with stall hold and flush abort.
module vector_store_sequencer #(
    parameter int LANES  = 16,
    parameter int LANE_W = 8,
    parameter int ADDR_W = 12
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic [ADDR_W-1:0]       req_base,
    input  logic [LANES*LANE_W-1:0] req_data,
    input  logic [LANES-1:0]        req_mask,
    input  logic                    flush,
    input  logic                    mem_stall,
    output logic [ADDR_W-1:0]       mem_addr,
    output logic [LANE_W-1:0]       mem_wdata,
    output logic                    mem_we,
    output logic                    busy,
    output logic                    done
);

    localparam int LW = (LANES > 1) ? $clog2(LANES) : 1;

    typedef enum logic [1:0] {IDLE, WRITE, DONE} state_t;

    state_t                    state, state_nx;
    logic [LW-1:0]             lane, lane_nx;
    logic [ADDR_W-1:0]         base;
    logic [LANES*LANE_W-1:0]   data;
    logic [LANES-1:0]          mask;
    logic                      capture;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            lane  <= '0;
            base  <= '0;
            data  <= '0;
            mask  <= '0;
        end else begin
            state <= state_nx;
            lane  <= lane_nx;
            if (capture) begin
                base <= req_base;
                data <= req_data;
                mask <= req_mask;
            end
        end
    end

    // mem_* depend only on captured registers, never on the live request inputs
    always_comb begin
        state_nx  = state;
        lane_nx   = lane;
        capture   = 1'b0;
        req_ready = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (!flush && req_valid) begin
                    capture  = 1'b1;
                    lane_nx  = '0;
                    state_nx = WRITE;
                end
            end
            WRITE: begin
                busy      = 1'b1;
                mem_addr  = base + ADDR_W'(lane);
                mem_wdata = data[lane*LANE_W +: LANE_W];
                mem_we    = mask[lane];
                if (flush) begin
                    lane_nx  = '0;
                    state_nx = IDLE;
                end else if (!mem_stall) begin
                    if (lane == LW'(LANES - 1)) begin
                        lane_nx  = '0;
                        state_nx = DONE;
                    end else begin
                        lane_nx = lane + 1'b1;
                    end
                end
            end
            DONE: begin
                done     = 1'b1;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

endmodule

// File: tb/tb_vector_store_sequencer.sv
// tb/tb_vector_store_sequencer.sv - scoreboard bench for vector_store_sequencer
module tb_vector_store_sequencer;
    localparam int LANES  = 16;
    localparam int LANE_W = 8;
    localparam int ADDR_W = 12;

    logic                    clk = 1'b0;
    logic                    rst;
    logic                    req_valid;
    logic                    req_ready;
    logic [ADDR_W-1:0]       req_base;
    logic [LANES*LANE_W-1:0] req_data;
    logic [LANES-1:0]        req_mask;
    logic                    flush;
    logic                    mem_stall;
    logic [ADDR_W-1:0]       mem_addr;
    logic [LANE_W-1:0]       mem_wdata;
    logic                    mem_we;
    logic                    busy;
    logic                    done;

    vector_store_sequencer #(.LANES(LANES), .LANE_W(LANE_W), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_base(req_base), .req_data(req_data), .req_mask(req_mask),
        .flush(flush), .mem_stall(mem_stall), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_we(mem_we), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int busy_cnt = 0;
    int done_cnt = 0;
    int done_cyc = 0;
    int wr_cnt = 0;
    int wr_cyc [0:1023];
    int e0 = 0;
    logic [ADDR_W+LANE_W-1:0] exp_q [$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", tag, act, exp);
        end
    endtask

    // Commits are taken where mem_we=1 and mem_stall=0, matching the write-port contract.
    always @(negedge clk) begin
        logic [ADDR_W+LANE_W-1:0] e;
        if (!rst) begin
            if (busy) busy_cnt++;
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
            if (mem_we && !mem_stall) begin
                if (wr_cnt < 1024) wr_cyc[wr_cnt] = cyc;
                wr_cnt++;
                check("wr_expected", exp_q.size() > 0, 1);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    check("wr_addr", mem_addr, e[ADDR_W+LANE_W-1:LANE_W]);
                    check("wr_data", mem_wdata, e[LANE_W-1:0]);
                end
            end
        end
    end

    task automatic nx();
        @(negedge clk);
        #1;
    endtask

    task automatic send(input logic [ADDR_W-1:0] b, input logic [LANES*LANE_W-1:0] d,
                        input logic [LANES-1:0] m);
        int t = 0;
        nx();
        while (!req_ready && t < 50) begin
            nx();
            t++;
        end
        check("send_ready", req_ready, 1);
        @(posedge clk); #1;
        req_valid = 1'b1;
        req_base  = b;
        req_data  = d;
        req_mask  = m;
        for (int i = 0; i < LANES; i++)
            if (m[i]) exp_q.push_back({b + ADDR_W'(i), d[i*LANE_W +: LANE_W]});
        @(posedge clk); #1;
        e0        = cyc;
        req_valid = 1'b0;
        req_data  = {$urandom(), $urandom(), $urandom(), $urandom()};
        req_base  = ADDR_W'($urandom());
        req_mask  = LANES'($urandom());
    endtask

    task automatic wait_done(input int target);
        int t = 0;
        while (done_cnt < target && t < 80) begin
            nx();
            t++;
        end
        check("done_seen", done_cnt >= target, 1);
    endtask

    function automatic logic [LANES*LANE_W-1:0] rand_vec();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [LANES*LANE_W-1:0] d, d2;
        int bc, dc, wc;
        rst = 1'b1; req_valid = 1'b0; req_base = '0; req_data = '0; req_mask = '0;
        flush = 1'b0; mem_stall = 1'b0;
        #12;
        check("rst_ready", req_ready, 1);
        check("rst_outs", {mem_we, busy, done, mem_addr, mem_wdata}, 0);
        @(posedge clk); #3 rst = 1'b0;

        // basic store
        for (int i = 0; i < LANES; i++) d[i*LANE_W +: LANE_W] = 8'h10 + 8'(i);
        bc = busy_cnt; dc = done_cnt; wc = wr_cnt;
        send(12'h100, d, 16'hFFFF);
        wait_done(dc + 1);
        check("basic_done_lat", done_cyc - e0, 16);
        check("basic_first_wr", wr_cyc[wc] - e0, 0);
        check("basic_last_wr", wr_cyc[wc+15] - e0, 15);
        check("basic_busy", busy_cnt - bc, 16);
        check("basic_q_empty", exp_q.size(), 0);
        nx();
        check("basic_ready_after", req_ready, 1);
        check("basic_done_width", done, 0);

        // wrap-around, with a request offered during DONE
        d = rand_vec(); d2 = rand_vec();
        dc = done_cnt; wc = wr_cnt;
        send(12'hFFC, d, 16'hFFFF);
        repeat (16) @(posedge clk);
        #1;
        check("wrap_in_done", done, 1);
        req_valid = 1'b1; req_base = 12'h400; req_data = d2; req_mask = 16'h0001;
        exp_q.push_back({12'h400, d2[7:0]});
        @(posedge clk); #1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        wait_done(dc + 2);
        check("wrap_contig", wr_cyc[wc+15] - wr_cyc[wc], 15);
        check("done_no_accept", wr_cyc[wc+16] - e0, 18);
        check("second_done_lat", done_cyc - e0, 34);
        check("wrap_q_empty", exp_q.size(), 0);

        // partial mask
        d = rand_vec();
        bc = busy_cnt; dc = done_cnt; wc = wr_cnt;
        send(12'h300, d, 16'h00F0);
        wait_done(dc + 1);
        check("mask_busy", busy_cnt - bc, 16);
        check("mask_writes", wr_cnt - wc, 4);
        check("mask_first_wr", wr_cyc[wc] - e0, 4);
        check("mask_last_wr", wr_cyc[wc+3] - e0, 7);
        check("mask_done_lat", done_cyc - e0, 16);
        nx();
        check("mask_done_once", done_cnt - dc, 1);

        // stall three cycles on lane 5
        d = rand_vec();
        bc = busy_cnt; dc = done_cnt; wc = wr_cnt;
        send(12'h200, d, 16'hFFFF);
        repeat (5) @(posedge clk);
        #1 mem_stall = 1'b1;
        for (int k = 0; k < 3; k++) begin
            nx();
            check("stall_addr", mem_addr, 12'h205);
            check("stall_data", mem_wdata, d[5*LANE_W +: LANE_W]);
            check("stall_we", mem_we, 1);
            @(posedge clk); #1;
        end
        mem_stall = 1'b0;
        wait_done(dc + 1);
        check("stall_done_lat", done_cyc - e0, 19);
        check("stall_busy", busy_cnt - bc, 19);
        check("stall_writes", wr_cnt - wc, 16);
        check("stall_last_wr", wr_cyc[wc+15] - e0, 18);

        // flush at lane 9
        d = rand_vec();
        dc = done_cnt; wc = wr_cnt;
        send(12'h500, d, 16'hFFFF);
        repeat (9) @(posedge clk);
        #1 flush = 1'b1;
        @(posedge clk); #1 flush = 1'b0;
        nx();
        check("flush_ready", req_ready, 1);
        check("flush_idle_outs", {busy, mem_we, done}, 0);
        check("flush_pending", exp_q.size(), 6);
        exp_q.delete();
        repeat (20) nx();
        check("flush_no_done", done_cnt - dc, 0);
        check("flush_writes", wr_cnt - wc, 10);
        @(posedge clk); #1;
        req_valid = 1'b1; flush = 1'b1; req_mask = 16'hFFFF;
        @(posedge clk); #1;
        req_valid = 1'b0; flush = 1'b0;
        nx();
        check("flush_prio_busy", busy, 0);
        d = rand_vec();
        dc = done_cnt;
        send(12'h600, d, 16'hFFFF);
        wait_done(dc + 1);
        check("post_flush_lat", done_cyc - e0, 16);
        check("post_flush_q", exp_q.size(), 0);

        // async reset at lane 7
        d = rand_vec();
        dc = done_cnt; wc = wr_cnt;
        send(12'h700, d, 16'hFFFF);
        repeat (7) @(posedge clk);
        #3 rst = 1'b1;
        #1;
        check("arst_ready", req_ready, 1);
        check("arst_outs", {mem_we, busy, done, mem_addr, mem_wdata}, 0);
        check("arst_pending", exp_q.size(), 9);
        exp_q.delete();
        repeat (2) @(posedge clk);
        #3 rst = 1'b0;
        repeat (3) nx();
        check("arst_writes", wr_cnt - wc, 7);
        check("arst_no_done", done_cnt - dc, 0);
        d = rand_vec();
        dc = done_cnt; wc = wr_cnt;
        send(12'h020, d, 16'hFFFF);
        wait_done(dc + 1);
        check("arst_new_first", wr_cyc[wc] - e0, 0);
        check("arst_new_q", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
